// File: rtl/wb_ram128_ctrl_if.sv
// Bus bundle for wb_ram128_ctrl: Wishbone slave side plus the synchronous RAM port.
// Signal names keep the controller's point of view (_i into the controller, _o out of it).
interface wb_ram128_ctrl_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [6:0]  ram_a_o;
    logic [31:0] ram_di_o;
    logic [31:0] ram_do_i;

    // Controller side.
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i, ram_do_i,
        output wb_dat_o, wb_ack_o, wb_err_o, ram_en_o, ram_we_o, ram_a_o, ram_di_o
    );

    // Bus master plus RAM model side.
    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i, ram_do_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, ram_en_o, ram_we_o, ram_a_o, ram_di_o
    );
endinterface

// File: rtl/wb_ram128_ctrl.sv
// Wishbone classic slave bridging to a 128 x 32 synchronous RAM with byte enables.
// Writes ack after 1 cycle, reads after 2 (RAM output is registered), misses return err.
module wb_ram128_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST_N,
    wb_ram128_ctrl_if.slave   bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;

    logic [1:0]  r_state;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;

    logic        w_req;
    logic        w_hit;
    logic        w_ram_en;

    assign w_req = bus.wb_cyc_i & bus.wb_stb_i & (r_state == S_IDLE);
    assign w_hit = (bus.wb_adr_i[31:9] == BASE_ADDR[31:9]);

    // The RAM strobe is combinational from IDLE, so reset must gate it explicitly.
    assign w_ram_en = RST_N & w_req & w_hit;

    assign bus.ram_en_o = w_ram_en;
    assign bus.ram_we_o = (w_ram_en & bus.wb_we_i) ? bus.wb_sel_i : 4'b0000;
    assign bus.ram_a_o  = bus.wb_adr_i[8:2];
    assign bus.ram_di_o = bus.wb_dat_i;

    assign bus.wb_ack_o = r_ack;
    assign bus.wb_err_o = r_err;
    assign bus.wb_dat_o = r_dat;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= 32'h0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (!w_hit) begin
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else if (bus.wb_we_i) begin
                            r_ack   <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    // Master abandoned the cycle: drop the read and keep old data.
                    if (!bus.wb_cyc_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_dat   <= bus.ram_do_i;
                        r_ack   <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_ram128_ctrl.md
WB_RAM128_CTRL -- requirements
Module: wb_ram128_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base of the 512-byte RAM window; bits [8:0] ignored.
REQ-002 SHALL have port CLK  input  1  single clock for all state; the RAM instance shares it.
REQ-003 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port wb_cyc_i  input  1  Wishbone cycle valid.
REQ-005 SHALL have port wb_stb_i  input  1  Wishbone strobe.
REQ-006 SHALL have port wb_we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port wb_sel_i  input  4  byte lane selects; bit n covers bits [8n+7:8n].
REQ-008 SHALL have port wb_adr_i  input  32  byte address.
REQ-009 SHALL have port wb_dat_i  input  32  write data.
REQ-010 SHALL have port wb_dat_o  output  32  registered read data.
REQ-011 SHALL have port wb_ack_o  output  1  registered transfer-complete pulse.
REQ-012 SHALL have port wb_err_o  output  1  registered out-of-window error pulse.
REQ-013 SHALL have port ram_en_o  output  1  RAM enable.
REQ-014 SHALL have port ram_we_o  output  4  RAM byte write enables.
REQ-015 SHALL have port ram_a_o  output  7  RAM word address.
REQ-016 SHALL have port ram_di_o  output  32  RAM write data.
REQ-017 SHALL have port ram_do_i  input  32  RAM read data; registered in the RAM, valid the cycle after an enabled edge, forced to 0 after any edge with EN=0.

Function
REQ-018 Request condition: wb_cyc_i & wb_stb_i in state IDLE.
REQ-019 Hit: wb_adr_i[31:9] == BASE_ADDR[31:9]. ram_a_o = wb_adr_i[8:2]; wb_adr_i[1:0] ignored.
REQ-020 FSM states: IDLE, RD_WAIT, RESP. Only IDLE accepts requests.
REQ-021 IDLE, request, hit, write: ram_en_o=1 and ram_we_o=wb_sel_i combinationally in the same cycle; ram_di_o=wb_dat_i; next edge sets wb_ack_o=1 and goes to RESP.
REQ-022 IDLE, request, hit, read: ram_en_o=1, ram_we_o=0; next edge goes to RD_WAIT.
REQ-023 RD_WAIT: ram_en_o=0; next edge loads wb_dat_o<=ram_do_i, sets wb_ack_o=1, goes to RESP.
REQ-024 IDLE, request, miss: no RAM access (ram_en_o=0); next edge sets wb_err_o=1 and goes to RESP.
REQ-025 RESP: wb_ack_o/wb_err_o high for exactly this one cycle; ram_en_o=0; next edge returns to IDLE regardless of wb_stb_i.
REQ-026 Latency, request edge to ack cycle: write 1 cycle, read 2 cycles, error 1 cycle. Back-to-back: a new request is accepted in the IDLE cycle after RESP.
REQ-027 Write with wb_sel_i=4'b0000: RAM enabled with ram_we_o=0, RAM content unchanged, ack still issued.
REQ-028 ram_en_o, ram_we_o SHALL be 0 in every cycle outside REQ-021/REQ-022; ram_a_o, ram_di_o are don't-care when ram_en_o=0.
REQ-029 wb_cyc_i low in RD_WAIT (abort): return to IDLE at the next edge, no ack, wb_dat_o unchanged.
REQ-030 wb_dat_o holds its last value until the next completed read; it is not cleared on writes or errors.
REQ-031 wb_ack_o and wb_err_o SHALL never be high in the same cycle.

Reset
REQ-032 RST_N low SHALL asynchronously force state IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
REQ-033 While RST_N is low, ram_en_o=0 and ram_we_o=0 regardless of bus inputs.
REQ-034 Reset asserted mid-transfer SHALL drop the transfer with no ack; operation resumes on the first edge after RST_N rises.

Verification
REQ-035 Write adr=0x0000_0010, dat=0xDEADBEEF, sel=4'hF, then read same adr -> write ack 1 cycle after request, read ack 2 cycles after request, wb_dat_o=0xDEADBEEF.
REQ-036 Preload word 5 with 0x11223344; write adr=0x14, sel=4'b0101, dat=0xAABBCCDD; read back -> 0x11BB33DD.
REQ-037 With BASE_ADDR=0x0000_0000, read adr=0x0000_0200 -> wb_err_o pulses 1 cycle, no ack, ram_en_o never high.
REQ-038 Back-to-back: 4 writes to words 0..3 (0x0,0x1,0x2,0x3), then 4 reads with stb held high between them -> exactly one ack per transfer, data 0x0..0x3, no duplicate RAM access in RESP cycles.
REQ-039 Read issued, wb_cyc_i dropped in RD_WAIT -> no ack, wb_dat_o keeps prior value; next read completes normally.
REQ-040 RST_N pulsed low during RD_WAIT -> wb_ack_o=0, wb_dat_o=0 immediately, FSM in IDLE; next write/read pair returns the written data.
